// File: rtl/iis_pkg.sv
// Shared types and constants for the iis DMA scheduler.
package iis_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_RL,
    ST_TX_WL,
    ST_TX_RR,
    ST_TX_WR,
    ST_TX_PUSH,
    ST_RX_WL,
    ST_RX_WR,
    ST_RX_POP
  } state_t;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 3;
  localparam int unsigned FRAME_STRIDE = 8;
  localparam int unsigned WORD_OFF     = 4;
  localparam int unsigned FIFO_MAX     = 7;

endpackage

// File: rtl/iis_ring_ptr.sv
// Ring frame pointer: advances with wrap at len-1, clears on request.
module iis_ring_ptr #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [LEN_W-1:0] len,
  input  logic             advance,
  input  logic             clear,
  output logic [LEN_W-1:0] ptr,
  output logic             wrap
);

  localparam int unsigned EXT_W = LEN_W + 1;

  // ptr >= len-1 counts as last, so a shrunken (or zeroed) len wraps on the next advance
  logic last;
  assign last = (EXT_W'(ptr) + EXT_W'(1)) >= EXT_W'(len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        if (last) begin
          ptr  <= '0;
          wrap <= 1'b1;
        end else begin
          ptr <= ptr + LEN_W'(1);
        end
      end else if (clear) begin
        ptr <= '0;
      end
    end
  end

endmodule

// File: rtl/iis_dma_sched.sv
// Schedules tx ring refills and rx ring drains over a single 32-bit memory port.
module iis_dma_sched
  import iis_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic [ADDR_W-1:0] tx_base,
  input  logic [ADDR_W-1:0] rx_base,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic [LEN_W-1:0]  rx_len,
  input  logic [2:0]        tx_wm,
  input  logic [2:0]        rx_wm,
  input  logic [2:0]        tx_cnt,
  input  logic [2:0]        rx_cnt,
  input  logic              tx_full,
  input  logic              rx_empty,
  output logic [31:0]       tx_data_l,
  output logic [31:0]       tx_data_r,
  output logic              tx_fill,
  input  logic [31:0]       rx_data_l,
  input  logic [31:0]       rx_data_r,
  output logic              rx_drain,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              tx_wrap_irq,
  output logic              rx_wrap_irq,
  output logic [LEN_W-1:0]  tx_ptr,
  output logic [LEN_W-1:0]  rx_ptr,
  output logic              busy
);

  state_t state;
  logic   rr_last_tx;

  logic tx_ok, rx_ok, rx_max, pick_tx, pick_rx;
  logic [ADDR_W-1:0] tx_addr, rx_addr;

  assign tx_ok  = tx_en && (tx_len != '0) && !tx_full && (tx_cnt <= tx_wm);
  assign rx_ok  = rx_en && (rx_len != '0) && !rx_empty && (rx_cnt >= rx_wm);
  assign rx_max = rx_cnt == CNT_W'(FIFO_MAX);

  // A full rx FIFO pre-empts; otherwise round-robin on ties
  assign pick_rx = rx_ok && (rx_max || !tx_ok || rr_last_tx);
  assign pick_tx = tx_ok && !pick_rx;

  assign tx_addr = tx_base + ADDR_W'(tx_ptr) * ADDR_W'(FRAME_STRIDE);
  assign rx_addr = rx_base + ADDR_W'(rx_ptr) * ADDR_W'(FRAME_STRIDE);

  // Disabled channel rewinds while idle; a frame in flight still finishes first
  logic tx_clr, rx_clr;
  assign tx_clr = (state == ST_IDLE) && !tx_en;
  assign rx_clr = (state == ST_IDLE) && !rx_en;

  iis_ring_ptr #(.LEN_W(LEN_W)) u_tx_ptr (
    .clk     (clk),
    .rstn    (rstn),
    .len     (tx_len),
    .advance (state == ST_TX_PUSH),
    .clear   (tx_clr),
    .ptr     (tx_ptr),
    .wrap    (tx_wrap_irq)
  );

  iis_ring_ptr #(.LEN_W(LEN_W)) u_rx_ptr (
    .clk     (clk),
    .rstn    (rstn),
    .len     (rx_len),
    .advance (state == ST_RX_POP),
    .clear   (rx_clr),
    .ptr     (rx_ptr),
    .wrap    (rx_wrap_irq)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      rr_last_tx <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tx_data_l  <= '0;
      tx_data_r  <= '0;
      tx_fill    <= 1'b0;
      rx_drain   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_tx) begin
            state      <= ST_TX_RL;
            rr_last_tx <= 1'b1;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= tx_addr;
          end else if (pick_rx) begin
            state      <= ST_RX_WL;
            rr_last_tx <= 1'b0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= rx_addr;
            mem_wdata  <= rx_data_l;
          end
        end
        ST_TX_RL: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= ST_TX_WL;
        end
        ST_TX_WL: if (mem_rvalid) begin
          tx_data_l <= mem_rdata;
          mem_req   <= 1'b1;
          mem_addr  <= mem_addr + ADDR_W'(WORD_OFF);
          state     <= ST_TX_RR;
        end
        ST_TX_RR: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= ST_TX_WR;
        end
        ST_TX_WR: if (mem_rvalid) begin
          tx_data_r <= mem_rdata;
          tx_fill   <= 1'b1;
          state     <= ST_TX_PUSH;
        end
        ST_TX_PUSH: begin
          tx_fill <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        ST_RX_WL: if (mem_gnt) begin
          mem_wdata <= rx_data_r;
          mem_addr  <= mem_addr + ADDR_W'(WORD_OFF);
          state     <= ST_RX_WR;
        end
        ST_RX_WR: if (mem_gnt) begin
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          rx_drain <= 1'b1;
          state    <= ST_RX_POP;
        end
        ST_RX_POP: begin
          rx_drain <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iis_dma_sched.sv
// Directed self-checking bench for iis_dma_sched with a simple grant/read-data responder.
module tb_iis_dma_sched;

  logic        clk;
  logic        rstn;
  logic        tx_en, rx_en;
  logic [31:0] tx_base, rx_base;
  logic [15:0] tx_len, rx_len;
  logic [2:0]  tx_wm, rx_wm, tx_cnt, rx_cnt;
  logic        tx_full, rx_empty;
  logic [31:0] tx_data_l, tx_data_r;
  logic        tx_fill;
  logic [31:0] rx_data_l, rx_data_r;
  logic        rx_drain;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        tx_wrap_irq, rx_wrap_irq;
  logic [15:0] tx_ptr, rx_ptr;
  logic        busy;

  logic        gnt_en;
  logic [7:0]  log_q[$];
  int          npass, ntotal;

  iis_dma_sched #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .tx_en(tx_en), .rx_en(rx_en),
    .tx_base(tx_base), .rx_base(rx_base),
    .tx_len(tx_len), .rx_len(rx_len),
    .tx_wm(tx_wm), .rx_wm(rx_wm),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .tx_full(tx_full), .rx_empty(rx_empty),
    .tx_data_l(tx_data_l), .tx_data_r(tx_data_r), .tx_fill(tx_fill),
    .rx_data_l(rx_data_l), .rx_data_r(rx_data_r), .rx_drain(rx_drain),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .tx_wrap_irq(tx_wrap_irq), .rx_wrap_irq(rx_wrap_irq),
    .tx_ptr(tx_ptr), .rx_ptr(rx_ptr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: grants in the request cycle, read data is address ^ 0xCAFE0000 one clk later
  assign mem_gnt = mem_req & gnt_en;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0;
    end else begin
      mem_rvalid <= mem_req & mem_gnt & ~mem_we;
      mem_rdata  <= mem_addr ^ 32'hCAFE_0000;
    end
  end

  // Frame order log: 'T' per tx_fill clk, 'R' per rx_drain clk
  always @(posedge clk) begin
    if (tx_fill)  log_q.push_back(8'h54);
    if (rx_drain) log_q.push_back(8'h52);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("log_wait", 32'(log_q.size() >= n), 32'h1);
  endtask

  task automatic idle_inputs();
    tx_en = 0; rx_en = 0;
    tx_base = 32'h1000; rx_base = 32'h2000;
    tx_len = 16'd0; rx_len = 16'd0;
    tx_wm = 3'd3; rx_wm = 3'd4; tx_cnt = 3'd0; rx_cnt = 3'd0;
    tx_full = 0; rx_empty = 1;
    rx_data_l = 32'h0; rx_data_r = 32'h0;
    gnt_en = 1;
  endtask

  task automatic do_reset();
    rstn = 0;
    tick(2);
    rstn = 1;
    tick(1);
    log_q.delete();
  endtask

  initial begin
    npass = 0; ntotal = 0;
    idle_inputs();
    rstn = 0;
    tick(3);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fill_drain", 32'({tx_fill, rx_drain}), 32'h0);
    chk("rst_ptrs", {tx_ptr, rx_ptr}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rstn = 1;
    tick(1);

    // tx only, len 2: two frames then wrap
    tx_base = 32'h1000; tx_len = 16'd2; tx_cnt = 3'd0; tx_wm = 3'd3; tx_en = 1;
    tick(1);
    chk("txA_req", 32'({mem_req, mem_we, busy}), 32'h5);
    chk("txA_addr0", mem_addr, 32'h1000);
    tick(2);
    chk("txA_addr1", mem_addr, 32'h1004);
    tick(2);
    chk("txA_fill0", 32'(tx_fill), 32'h1);
    chk("txA_l0", tx_data_l, 32'hCAFE_1000);
    chk("txA_r0", tx_data_r, 32'hCAFE_1004);
    tick(1);
    chk("txA_ptr1", 32'(tx_ptr), 32'h1);
    chk("txA_fill_off", 32'(tx_fill), 32'h0);
    tick(1);
    chk("txA_addr2", mem_addr, 32'h1008);
    tick(2);
    chk("txA_addr3", mem_addr, 32'h100C);
    tick(2);
    chk("txA_fill1", 32'(tx_fill), 32'h1);
    chk("txA_l1", tx_data_l, 32'hCAFE_1008);
    chk("txA_r1", tx_data_r, 32'hCAFE_100C);
    tx_en = 0;
    tick(1);
    chk("txA_wrap", 32'(tx_wrap_irq), 32'h1);
    chk("txA_ptr_wrap", 32'(tx_ptr), 32'h0);
    tick(1);
    chk("txA_wrap_off", 32'(tx_wrap_irq), 32'h0);
    chk("txA_quiet", 32'({mem_req, busy}), 32'h0);

    // rx only: one frame written to rx_base/+4
    rx_base = 32'h2000; rx_len = 16'd4; rx_cnt = 3'd4; rx_wm = 3'd4; rx_empty = 0;
    rx_data_l = 32'hA5A5_0001; rx_data_r = 32'h5A5A_0002; rx_en = 1;
    log_q.delete();
    tick(1);
    chk("rxB_we", 32'({mem_req, mem_we}), 32'h3);
    chk("rxB_addr0", mem_addr, 32'h2000);
    chk("rxB_wd0", mem_wdata, 32'hA5A5_0001);
    tick(1);
    chk("rxB_addr1", mem_addr, 32'h2004);
    chk("rxB_wd1", mem_wdata, 32'h5A5A_0002);
    chk("rxB_no_early_drain", 32'(rx_drain), 32'h0);
    tick(1);
    chk("rxB_drain", 32'(rx_drain), 32'h1);
    rx_empty = 1;
    tick(1);
    chk("rxB_ptr1", 32'(rx_ptr), 32'h1);
    chk("rxB_req_off", 32'({mem_req, rx_drain}), 32'h0);
    tick(4);
    chk("rxB_one_drain", 32'(log_q.size()), 32'h1);

    // Both eligible: alternate starting with tx
    idle_inputs();
    do_reset();
    tx_len = 16'd4; tx_cnt = 3'd2; tx_wm = 3'd3; tx_en = 1;
    rx_len = 16'd4; rx_cnt = 3'd5; rx_wm = 3'd4; rx_empty = 0; rx_en = 1;
    wait_log(4, 100);
    chk("rr_0", 32'(log_q[0]), 32'h54);
    chk("rr_1", 32'(log_q[1]), 32'h52);
    chk("rr_2", 32'(log_q[2]), 32'h54);
    chk("rr_3", 32'(log_q[3]), 32'h52);
    tx_en = 0; rx_en = 0;
    tick(10);

    // rx FIFO at max pre-empts tx even though rr favours tx
    idle_inputs();
    do_reset();
    tx_len = 16'd4; tx_cnt = 3'd0; tx_en = 1;
    rx_len = 16'd4; rx_cnt = 3'd7; rx_wm = 3'd4; rx_empty = 0; rx_en = 1;
    tick(1);
    chk("max_we", 32'(mem_we), 32'h1);
    chk("max_addr", mem_addr, 32'h2000);
    wait_log(1, 20);
    chk("max_first", 32'(log_q[0]), 32'h52);
    tx_en = 0; rx_en = 0;
    tick(10);

    // Grant stall for 10 clk, tx_en dropped during the stall
    idle_inputs();
    do_reset();
    gnt_en = 0;
    tx_base = 32'h3000; tx_len = 16'd4; tx_en = 1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", 32'(mem_req), 32'h1);
      chk("stall_addr", mem_addr, 32'h3000);
      chk("stall_nofill", 32'(tx_fill), 32'h0);
      if (i == 4) tx_en = 0;
      tick(1);
    end
    gnt_en = 1;
    wait_log(1, 30);
    tick(6);
    chk("stall_one_fill", 32'(log_q.size()), 32'h1);
    chk("stall_data_r", tx_data_r, 32'hCAFE_3004);
    chk("stall_ptr_cleared", 32'(tx_ptr), 32'h0);
    chk("stall_idle", 32'({mem_req, busy}), 32'h0);

    // Reset asserted while waiting for R data
    idle_inputs();
    do_reset();
    tx_base = 32'h1000; tx_len = 16'd4; tx_en = 1;
    tick(4);
    chk("rstF_midframe", 32'({busy, mem_req}), 32'h2);
    chk("rstF_l_held", tx_data_l, 32'hCAFE_1000);
    rstn = 0;
    #1;
    chk("rstF_async_out", 32'({mem_req, busy, tx_fill}), 32'h0);
    chk("rstF_async_l", tx_data_l, 32'h0);
    tick(1);
    chk("rstF_held", 32'({mem_req, busy, tx_fill, rx_drain}), 32'h0);
    tx_en = 0;
    log_q.delete();
    tick(1);
    rstn = 1;
    tick(8);
    chk("rstF_no_fill", 32'(log_q.size()), 32'h0);
    chk("rstF_ptr", 32'(tx_ptr), 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
